spawn_scheduler: RTL and testbench

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_scheduler.sv | 172 +++++++++++++++++
 tb/tb_spawn_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: paces block spawns per difficulty level and picks a
// lane from an external LFSR, avoiding repeats of the previous lane.
module spawn_scheduler #(
  parameter int unsigned LANES            = 5,
  parameter int unsigned BASE_INTERVAL    = 60,
  parameter int unsigned MIN_INTERVAL     = 12,
  parameter int unsigned LEVEL_STEP       = 4,
  parameter int unsigned SPAWNS_PER_LEVEL = 8,
  parameter int unsigned MAX_LEVEL        = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       restart,
  input  logic       tick,
  input  logic [7:0] rnd,
  output logic       rnd_step,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [2:0] spawn_lane,
  output logic [1:0] spawn_speed,
  output logic [3:0] level
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] DRAW  = 3'd2;
  localparam logic [2:0] EVAL  = 3'd3;
  localparam logic [2:0] OFFER = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [2:0] retry_q, retry_d;
  logic [2:0] lane_q, lane_d;
  logic [1:0] speed_q, speed_d;
  logic [3:0] level_q, level_d;
  logic [7:0] spcnt_q, spcnt_d;
  logic [2:0] last_q, last_d;
  logic       lastv_q, lastv_d;

  logic [2:0] cand;
  logic       reject;
  logic [2:0] forced;
  logic [1:0] speed_nx;
  logic       xfer;
  logic       lvl_up;
  logic [3:0] level_nx;
  logic [7:0] spcnt_nx;
  logic       unused_rnd;

  assign unused_rnd = ^rnd[5:3];

  // Floor compare done before subtracting so it never wraps
  function automatic logic [7:0] interval(input logic [3:0] l);
    int unsigned red;
    red = 32'(l) * LEVEL_STEP;
    if (BASE_INTERVAL >= MIN_INTERVAL + red)
      return 8'(BASE_INTERVAL - red);
    return 8'(MIN_INTERVAL);
  endfunction

  assign cand   = rnd[2:0];
  assign reject = (32'(cand) >= LANES) ||
                  (lastv_q && cand == last_q);
  assign forced = (32'(last_q) == LANES - 1) ?
                  3'd0 : last_q + 3'd1;
  assign speed_nx = (rnd[7:6] < level_q[3:2]) ?
                    rnd[7:6] : level_q[3:2];

  assign xfer     = (state_q == OFFER) && spawn_ready;
  assign lvl_up   = (32'(spcnt_q) == SPAWNS_PER_LEVEL - 1);
  assign spcnt_nx = lvl_up ? 8'd0 : spcnt_q + 8'd1;
  assign level_nx = (!lvl_up || 32'(level_q) >= MAX_LEVEL) ?
                    level_q : level_q + 4'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    retry_d = retry_q;
    lane_d  = lane_q;
    speed_d = speed_q;
    level_d = level_q;
    spcnt_d = spcnt_q;
    last_d  = last_q;
    lastv_d = lastv_q;
    if (restart) begin
      state_d = IDLE;
      level_d = 4'd0;
      spcnt_d = 8'd0;
      retry_d = 3'd0;
      lastv_d = 1'b0;
    end else if (!run && state_q != IDLE) begin
      state_d = IDLE;
      retry_d = 3'd0;
      if (xfer) begin
        last_d  = lane_q;
        lastv_d = 1'b1;
        spcnt_d = spcnt_nx;
        level_d = level_nx;
      end
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          if (run) begin
            count_d = interval(level_q);
            state_d = WAIT;
          end
        end
        state_q == WAIT: begin
          if (tick) begin
            if (count_q == 8'd1) state_d = DRAW;
            else count_d = count_q - 8'd1;
          end
        end
        state_q == DRAW: state_d = EVAL;
        state_q == EVAL: begin
          if (reject && retry_q != 3'd7) begin
            retry_d = retry_q + 3'd1;
            state_d = DRAW;
          end else begin
            lane_d  = reject ? forced : cand;
            speed_d = speed_nx;
            retry_d = 3'd0;
            state_d = OFFER;
          end
        end
        state_q == OFFER: begin
          if (spawn_ready) begin
            last_d  = lane_q;
            lastv_d = 1'b1;
            spcnt_d = spcnt_nx;
            level_d = level_nx;
            count_d = interval(level_nx);
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      retry_q <= 3'd0;
      lane_q  <= 3'd0;
      speed_q <= 2'd0;
      level_q <= 4'd0;
      spcnt_q <= 8'd0;
      last_q  <= 3'd0;
      lastv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      retry_q <= retry_d;
      lane_q  <= lane_d;
      speed_q <= speed_d;
      level_q <= level_d;
      spcnt_q <= spcnt_d;
      last_q  <= last_d;
      lastv_q <= lastv_d;
    end
  end

  assign rnd_step    = (state_q == DRAW);
  assign spawn_valid = (state_q == OFFER);
  assign spawn_lane  = lane_q;
  assign spawn_speed = speed_q;
  assign level       = level_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with small intervals and
// two spawns per level; ticks arrive every cycle.
module tb_spawn_scheduler;

  logic       clk = 1'b0;
  logic       reset, run, restart, tick, spawn_ready;
  logic [7:0] rnd;
  logic       rnd_step, spawn_valid;
  logic [2:0] spawn_lane;
  logic [1:0] spawn_speed;
  logic [3:0] level;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc, pul;

  logic [7:0] rv_a [4] = '{8'h00, 8'h04, 8'h00, 8'h04};
  logic [7:0] rv_b [6] = '{8'h00, 8'h01, 8'h00,
                           8'h01, 8'h00, 8'h01};
  int cy_b [6] = '{7, 6, 5, 5, 4, 4};

  spawn_scheduler #(
    .LANES(5), .BASE_INTERVAL(4), .MIN_INTERVAL(2),
    .LEVEL_STEP(1), .SPAWNS_PER_LEVEL(2), .MAX_LEVEL(15)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .restart(restart), .tick(tick), .rnd(rnd),
    .rnd_step(rnd_step), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
    .spawn_speed(spawn_speed), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // First EVAL sees r0, later EVALs see r1
  task automatic run_spawn(input logic [7:0] r0,
                           input logic [7:0] r1,
                           output int c, output int p);
    c = 0;
    p = 0;
    rnd = r0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      c++;
      if (spawn_valid) return;
      if (rnd_step) begin
        p++;
        rnd = (p == 1) ? r0 : r1;
      end
    end
    c = -1;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    restart = 1'b0;
    tick = 1'b1;
    spawn_ready = 1'b1;
    rnd = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(spawn_valid), 0);
    chk("rst_step", 32'(rnd_step), 0);
    chk("rst_lane", 32'(spawn_lane), 0);
    chk("rst_speed", 32'(spawn_speed), 0);
    chk("rst_level", 32'(level), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(spawn_valid), 0);
    run = 1'b1;

    run_spawn(8'h03, 8'h03, cyc, pul);
    chk("s1_cyc", cyc, 7);
    chk("s1_pulses", pul, 1);
    chk("s1_lane", 32'(spawn_lane), 3);
    chk("s1_speed", 32'(spawn_speed), 0);
    @(negedge clk);
    chk("s1_drop", 32'(spawn_valid), 0);

    run_spawn(8'h07, 8'h02, cyc, pul);
    chk("s2_cyc", cyc, 8);
    chk("s2_pulses", pul, 2);
    chk("s2_lane", 32'(spawn_lane), 2);
    @(negedge clk);
    chk("s2_drop", 32'(spawn_valid), 0);
    chk("s2_level", 32'(level), 1);

    run_spawn(8'h02, 8'h02, cyc, pul);
    chk("s3_cyc", cyc, 19);
    chk("s3_pulses", pul, 8);
    chk("s3_lane", 32'(spawn_lane), 3);
    @(negedge clk);

    run_spawn(8'h01, 8'h01, cyc, pul);
    chk("s4_cyc", cyc, 5);
    chk("s4_lane", 32'(spawn_lane), 1);
    @(negedge clk);
    chk("s4_level", 32'(level), 2);

    for (int k = 0; k < 4; k++) begin
      run_spawn(rv_a[k], rv_a[k], cyc, pul);
      chk("s5_cyc", cyc, 4);
      chk("s5_lane", 32'(spawn_lane), 32'(rv_a[k]));
      @(negedge clk);
    end
    chk("s5_level", 32'(level), 4);

    spawn_ready = 1'b0;
    run_spawn(8'hC1, 8'hC1, cyc, pul);
    chk("s6_cyc", cyc, 4);
    chk("s6_lane", 32'(spawn_lane), 1);
    chk("s6_speed", 32'(spawn_speed), 1);
    for (int k = 0; k < 10; k++) begin
      rnd = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(spawn_valid), 1);
      chk("hold_lane", 32'(spawn_lane), 1);
      chk("hold_speed", 32'(spawn_speed), 1);
      chk("hold_step", 32'(rnd_step), 0);
    end
    spawn_ready = 1'b1;
    @(negedge clk);
    chk("s6_drop", 32'(spawn_valid), 0);
    @(negedge clk);
    chk("s6_single", 32'(spawn_valid), 0);
    chk("s6_level", 32'(level), 4);

    spawn_ready = 1'b0;
    run_spawn(8'h00, 8'h00, cyc, pul);
    chk("s7_cyc", cyc, 3);
    chk("s7_valid", 32'(spawn_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(spawn_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_speed", 32'(spawn_speed), 0);
    @(negedge clk);
    reset = 1'b0;
    spawn_ready = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_spawn(rv_b[k], rv_b[k], cyc, pul);
      chk("s8_cyc", cyc, cy_b[k]);
      chk("s8_lane", 32'(spawn_lane), 32'(rv_b[k]));
      @(negedge clk);
    end
    chk("s8_level", 32'(level), 3);

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_level", 32'(level), 0);
    chk("rs_valid", 32'(spawn_valid), 0);
    run_spawn(8'h01, 8'h01, cyc, pul);
    chk("rs_cyc", cyc, 7);
    chk("rs_pulses", pul, 1);
    chk("rs_lane", 32'(spawn_lane), 1);
    @(negedge clk);
    chk("rs_drop", 32'(spawn_valid), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
